// File: rtl/regfile_write_arbiter_pkg.sv
// Shared defaults and the writeback priority state type
// for the register-file write-port arbiter.
package regfile_write_arbiter_pkg;

  localparam int unsigned DATA_W_DEF   = 64;
  localparam int unsigned ADDR_W_DEF   = 5;
  localparam int unsigned ZERO_REG_DEF = 31;
  localparam int unsigned WAIT_W       = 4;

  typedef enum logic {
    PRI_P0 = 1'b0,
    PRI_P1 = 1'b1
  } wb_pri_e;

endpackage

// File: rtl/regfile_write_arbiter_wb_priority_fsm.sv
// Priority state plus starvation counter: hands priority to port 1
// once it has been refused MAX_WAIT times, and back after it writes.
module wb_priority_fsm
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    p1_refused,
  input  logic    p1_accepted,
  input  logic    p1_real_accepted,
  output wb_pri_e pri_sel,
  output logic    p1_starving
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  wb_pri_e           state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PRI_P0;
      wait_q      <= '0;
      p1_starving <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      p1_starving <= (state_d == PRI_P1);
    end
  end

  // Swap priority on the edge where the counter reaches its limit.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    if (p1_accepted) begin
      wait_d = '0;
    end else if (p1_refused && (wait_q < WAIT_MAX)) begin
      wait_d = wait_q + WAIT_W'(1);
    end
    case (state_q)
      PRI_P0: if (wait_d == WAIT_MAX) state_d = PRI_P1;
      PRI_P1: if (p1_real_accepted) state_d = PRI_P0;
      default: state_d = PRI_P0;
    endcase
  end

  assign pri_sel = state_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register bank write port between load writeback (port 0)
// and ALU writeback (port 1); zero-register writes are absorbed here.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned ZERO_REG  = ZERO_REG_DEF,
  parameter int unsigned DROP_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic [ADDR_W-1:0] p0_reg,
  input  logic [DATA_W-1:0] p0_data,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [ADDR_W-1:0] p1_reg,
  input  logic [DATA_W-1:0] p1_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_reg,
  output logic [DATA_W-1:0] wr_data,
  output logic              p1_starving
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
  localparam logic              DROP_EN  = (DROP_ZERO != 0);

  logic    p0_drop, p1_drop;
  logic    p0_real, p1_real;
  logic    p0_grant, p1_grant;
  wb_pri_e pri_sel;

  assign p0_drop = p0_valid && DROP_EN && (p0_reg == ZERO_IDX);
  assign p1_drop = p1_valid && DROP_EN && (p1_reg == ZERO_IDX);
  assign p0_real = p0_valid && !p0_drop;
  assign p1_real = p1_valid && !p1_drop;

  // Same-register conflicts always go to the older port 0 so port 1 lands last.
  always_comb begin
    p0_grant = 1'b0;
    p1_grant = 1'b0;
    if (p0_real && p1_real) begin
      if ((p0_reg == p1_reg) || (pri_sel == PRI_P0)) p0_grant = 1'b1;
      else                                           p1_grant = 1'b1;
    end else begin
      p0_grant = p0_real;
      p1_grant = p1_real;
    end
  end

  assign p0_ready = rst_n && (p0_drop || p0_grant);
  assign p1_ready = rst_n && (p1_drop || p1_grant);

  wb_priority_fsm #(
    .MAX_WAIT (MAX_WAIT)
  ) u_fsm (
    .clk              (clk),
    .rst_n            (rst_n),
    .p1_refused       (p1_real && !p1_grant),
    .p1_accepted      (p1_valid && p1_ready),
    .p1_real_accepted (p1_grant),
    .pri_sel          (pri_sel),
    .p1_starving      (p1_starving)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_reg  <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= p0_grant || p1_grant;
      if (p0_grant) begin
        wr_reg  <= p0_reg;
        wr_data <= p0_data;
      end else if (p1_grant) begin
        wr_reg  <= p1_reg;
        wr_data <= p1_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized checks of regfile_write_arbiter against a
// behavioural arbitration model and a shadow register bank.
module tb_regfile_write_arbiter;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 5;
  localparam int unsigned MW = 4;
  localparam int unsigned ZR = 31;

  logic          clk, rst_n;
  logic          p0_valid, p1_valid;
  logic [AW-1:0] p0_reg, p1_reg;
  logic [DW-1:0] p0_data, p1_data;
  logic          p0_ready, p1_ready, wr_en, p1_starving;
  logic [AW-1:0] wr_reg;
  logic [DW-1:0] wr_data;
  logic          nz_p0_ready, nz_p1_ready, nz_wr_en, nz_p1_starving;
  logic [AW-1:0] nz_wr_reg;
  logic [DW-1:0] nz_wr_data;

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW), .ZERO_REG(ZR), .DROP_ZERO(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_reg(p0_reg), .p0_data(p0_data),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_reg(p1_reg), .p1_data(p1_data),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .p1_starving(p1_starving));

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW), .ZERO_REG(ZR), .DROP_ZERO(0)) u_dut_nz (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_ready(nz_p0_ready), .p0_reg(p0_reg), .p0_data(p0_data),
    .p1_valid(p1_valid), .p1_ready(nz_p1_ready), .p1_reg(p1_reg), .p1_data(p1_data),
    .wr_en(nz_wr_en), .wr_reg(nz_wr_reg), .wr_data(nz_wr_data), .p1_starving(nz_p1_starving));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: who has priority, how long port 1 has waited,
  // and what the output stage should present.
  bit            m_pri1;
  int unsigned   m_wait;
  bit            m_wr_en;
  logic [AW-1:0] m_wr_reg;
  logic [DW-1:0] m_wr_data;
  logic [DW-1:0] bank_exp [32];
  logic [DW-1:0] bank_dut [32];
  bit            obs0, obs1, exp0, exp1, nzr0, nzr1;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_pri1 = 0; m_wait = 0; m_wr_en = 0; m_wr_reg = '0; m_wr_data = '0;
  endtask

  // One cycle: drive, check readies, advance model, clock, check outputs.
  task automatic step(input bit v0, input logic [AW-1:0] r0, input logic [DW-1:0] d0,
                      input bit v1, input logic [AW-1:0] r1, input logic [DW-1:0] d1);
    bit z0, z1, q0, q1, g0, g1;
    p0_valid = v0; p0_reg = r0; p0_data = d0;
    p1_valid = v1; p1_reg = r1; p1_data = d1;
    #1;
    z0 = v0 && (r0 == AW'(ZR));
    z1 = v1 && (r1 == AW'(ZR));
    q0 = v0 && !z0;
    q1 = v1 && !z1;
    if (q0 && q1) g0 = (r0 == r1) || !m_pri1;
    else          g0 = q0;
    g1 = q1 && !g0;
    exp0 = z0 || g0;
    exp1 = z1 || g1;
    obs0 = p0_ready; obs1 = p1_ready;
    nzr0 = nz_p0_ready; nzr1 = nz_p1_ready;
    chk("p0_ready", {63'd0, p0_ready}, {63'd0, exp0});
    chk("p1_ready", {63'd0, p1_ready}, {63'd0, exp1});
    if (wr_en)   bank_dut[wr_reg] = wr_data;
    if (m_wr_en) bank_exp[m_wr_reg] = m_wr_data;
    if (v1 && exp1) m_wait = 0;
    else if (q1 && !g1 && m_wait < MW) m_wait++;
    if (m_pri1) begin
      if (g1) m_pri1 = 0;
    end else if (m_wait == MW) m_pri1 = 1;
    m_wr_en = g0 || g1;
    if (g0) begin m_wr_reg = r0; m_wr_data = d0; end
    else if (g1) begin m_wr_reg = r1; m_wr_data = d1; end
    @(posedge clk); #1;
    chk("wr_en", {63'd0, wr_en}, {63'd0, m_wr_en});
    chk("wr_reg", {59'd0, wr_reg}, {59'd0, m_wr_reg});
    chk("wr_data", wr_data, m_wr_data);
    chk("p1_starving", {63'd0, p1_starving}, {63'd0, m_pri1});
  endtask

  task automatic do_reset();
    rst_n = 0; p0_valid = 0; p1_valid = 0;
    m_reset();
    @(posedge clk); #1;
    rst_n = 1;
    #1;
  endtask

  initial begin
    int cnt;
    bit got;
    bit pend0, pend1;
    logic [AW-1:0] rr0, rr1;
    logic [DW-1:0] dd0, dd1;
    logic [AW-1:0] regs [5];
    regs = '{5'd1, 5'd2, 5'd3, 5'd7, 5'd31};
    for (int i = 0; i < 32; i++) begin bank_exp[i] = '0; bank_dut[i] = '0; end
    rst_n = 0; p0_valid = 0; p1_valid = 0; p0_reg = '0; p1_reg = '0; p0_data = '0; p1_data = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
    chk("rst_wr_reg", {59'd0, wr_reg}, 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    chk("rst_starving", {63'd0, p1_starving}, 64'd0);
    p0_valid = 1;
    #1;
    chk("rst_p0_ready", {63'd0, p0_ready}, 64'd0);
    p0_valid = 0;
    rst_n = 1;
    #1;

    // Single port 0 write.
    step(1, 5'd5, 64'hA5, 0, 5'd0, 64'd0);
    chk("single_ready", {63'd0, obs0}, 64'd1);
    chk("single_wr_reg", {59'd0, wr_reg}, 64'd5);
    chk("single_wr_data", wr_data, 64'hA5);
    step(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
    chk("single_wr_en_off", {63'd0, wr_en}, 64'd0);

    // Continuous conflict on different registers: starvation guard.
    cnt = 0; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step(1, 5'd1, 64'h100 + 64'(i), 1, 5'd2, 64'h200);
      if (obs1) got = 1;
      else if (obs0) cnt++;
    end
    chk("starve_p1_won", {63'd0, got}, 64'd1);
    chk("starve_p0_wins", 64'(cnt), 64'd4);
    chk("starve_cleared", {63'd0, p1_starving}, 64'd0);

    // Re-enter PRI_P1, then same-register conflict on reg 7.
    for (int i = 0; i < 4; i++) step(1, 5'd1, 64'h300, 1, 5'd2, 64'h400);
    chk("pri1_entered", {63'd0, p1_starving}, 64'd1);
    step(1, 5'd7, 64'h11, 1, 5'd7, 64'h22);
    chk("same_p0_first", {62'd0, obs0, obs1}, 64'd2);
    step(0, 5'd0, 64'd0, 1, 5'd7, 64'h22);
    chk("same_p1_next", {63'd0, obs1}, 64'd1);
    step(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
    step(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
    chk("same_bank_r7", bank_dut[7], 64'h22);

    // Zero register handling, with and without dropping.
    do_reset();
    step(1, 5'd31, 64'hAA, 1, 5'd3, 64'hBB);
    chk("zero_both_ready", {62'd0, obs0, obs1}, 64'd3);
    chk("zero_wr_reg3", {59'd0, wr_reg}, 64'd3);
    chk("nz_p0_first", {62'd0, nzr0, nzr1}, 64'd2);
    chk("nz_wr_reg31", {58'd0, nz_wr_en, nz_wr_reg}, {58'd0, 1'b1, 5'd31});
    step(0, 5'd0, 64'd0, 1, 5'd3, 64'hBB);
    chk("nz_p1_next", {63'd0, nzr1}, 64'd1);
    chk("nz_wr_reg3", {58'd0, nz_wr_en, nz_wr_reg}, {58'd0, 1'b1, 5'd3});
    step(1, 5'd31, 64'h1, 1, 5'd31, 64'h2);
    chk("zero_both_zr", {62'd0, obs0, obs1}, 64'd3);
    chk("zero_both_no_wr", {63'd0, wr_en}, 64'd0);

    // Randomized requesters that hold requests until transferred.
    pend0 = 0; pend1 = 0; rr0 = '0; rr1 = '0; dd0 = '0; dd1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend0 && $urandom_range(0, 3) != 0) begin
        pend0 = 1; rr0 = regs[$urandom_range(0, 4)]; dd0 = {$urandom, $urandom};
      end
      if (!pend1 && $urandom_range(0, 3) != 0) begin
        pend1 = 1; rr1 = regs[$urandom_range(0, 4)]; dd1 = {$urandom, $urandom};
      end
      step(pend0, rr0, dd0, pend1, rr1, dd1);
      if (exp0) pend0 = 0;
      if (exp1) pend1 = 0;
    end
    step(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
    step(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
    for (int i = 0; i < 32; i++) chk($sformatf("bank_r%0d", i), bank_dut[i], bank_exp[i]);

    // Reset while the output stage holds a write.
    step(1, 5'd9, 64'h99, 0, 5'd0, 64'd0);
    chk("mid_wr_en_before", {63'd0, wr_en}, 64'd1);
    rst_n = 0;
    m_reset();
    #1;
    chk("mid_wr_en_async", {63'd0, wr_en}, 64'd0);
    chk("mid_ready_low", {62'd0, p0_ready, p1_ready}, 64'd0);
    p0_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;
    #1;
    chk("mid_wr_reg", {59'd0, wr_reg}, 64'd0);
    chk("mid_wr_data", wr_data, 64'd0);
    chk("mid_starving", {63'd0, p1_starving}, 64'd0);
    step(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
    step(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
    chk("mid_no_write_r9", bank_dut[9], bank_exp[9]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
